// File: rtl/ospfb_power_acc.sv
// ospfb_power_acc: spectrometer back-end for the OSPFB FFT output.
// Computes per-bin power re^2+im^2, integrates it over ACC_LEN frames and emits one
// accumulated spectrum per integration through a first-word-fall-through output FIFO.
// Bin index and tlast are checked on every beat; a mismatch drops the partial integration
// and the block waits for the next tlast to realign.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   s_axis_*        FFT bins {im,re}, tlast on the last bin, tuser = bin index (no backpressure)
//   m_axis_*        accumulated power, tuser = bin, tlast on bin FFT_LEN-1
//   event_sync_err  1-cycle pulse on a framing error
//   event_fifo_ovf  1-cycle pulse when an output word is dropped on a full FIFO
//   event_acc_sat   1-cycle pulse when an accumulator sum saturates
//   acc_frame       frame number within the current integration
module ospfb_power_acc #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FFT_LEN   = 32,
  parameter int unsigned ACC_LEN   = 4,
  parameter int unsigned ACC_WID   = 48,
  parameter int unsigned OFIFO_DEP = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*WIDTH-1:0]         s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic [7:0]                 s_axis_tuser,
  output logic [ACC_WID-1:0]         m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [7:0]                 m_axis_tuser,
  output logic                       event_sync_err,
  output logic                       event_fifo_ovf,
  output logic                       event_acc_sat,
  output logic [$clog2(ACC_LEN):0]   acc_frame
);

  localparam int unsigned BW = $clog2(FFT_LEN);
  localparam int unsigned FW = $clog2(ACC_LEN) + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = $clog2(OFIFO_DEP);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = ACC_WID + BW + 1;

  localparam logic [BW-1:0]      LastBin   = BW'(FFT_LEN - 1);
  localparam logic [FW-1:0]      LastFrame = FW'(ACC_LEN - 1);
  localparam logic [ACC_WID-1:0] SatMax    = '1;

  typedef enum logic [0:0] {StSync, StAccum} state_e;

  // ---------------------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic            sync_err, take;
  logic            sync_err_q;
  logic [BW-1:0]   in_bin;
  logic            bin_is_last;
  logic            unused_tuser;

  assign in_bin       = s_axis_tuser[BW-1:0];
  assign unused_tuser = ^s_axis_tuser[7:BW];
  assign bin_is_last  = (bin_q == LastBin);

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bin_d    = bin_q;
    sync_err = 1'b0;
    take     = 1'b0;
    if (s_axis_tvalid) begin
      unique case (state_q)
        StSync: begin
          if (s_axis_tlast) begin
            state_d = StAccum;
            frame_d = '0;
            bin_d   = '0;
          end
        end
        StAccum: begin
          if ((in_bin != bin_q) || (s_axis_tlast != bin_is_last)) begin
            sync_err = 1'b1;
            frame_d  = '0;
            bin_d    = '0;
            // A bad beat that carries tlast still marks a frame boundary: realign at once.
            state_d  = s_axis_tlast ? StAccum : StSync;
          end else begin
            take  = 1'b1;
            bin_d = bin_is_last ? '0 : bin_q + 1'b1;
            if (s_axis_tlast) begin
              frame_d = (frame_q == LastFrame) ? '0 : frame_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSync;
      frame_q    <= '0;
      bin_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bin_q      <= bin_d;
      sync_err_q <= sync_err;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Datapath: S0 beat + RAM read, S1 power, S2 accumulate/saturate, then RAM or FIFO write
  // ---------------------------------------------------------------------------------------
  logic                      s0_valid, s0_first, s0_out;
  logic signed [WIDTH-1:0]   s0_re, s0_im;
  logic [BW-1:0]             s0_bin;
  logic [ACC_WID-1:0]        ram_rd;

  logic                      s1_valid, s1_out;
  logic [PW-1:0]             s1_power;
  logic [ACC_WID-1:0]        s1_prev;
  logic [BW-1:0]             s1_bin;

  logic                      s2_valid, s2_out;
  logic [ACC_WID-1:0]        s2_sum;
  logic [BW-1:0]             s2_bin;
  logic                      sat_q;

  logic signed [PW-1:0]      re_sq, im_sq;
  logic [PW-1:0]             power;
  logic [ACC_WID:0]          sum_full;
  logic [ACC_WID-1:0]        sum_sat;

  logic [ACC_WID-1:0]        ram [FFT_LEN];

  // Each square is at most 2^(2*WIDTH-2), so the unsigned sum fits 2*WIDTH bits exactly.
  assign re_sq    = PW'(s0_re) * PW'(s0_re);
  assign im_sq    = PW'(s0_im) * PW'(s0_im);
  assign power    = $unsigned(re_sq) + $unsigned(im_sq);
  assign sum_full = {1'b0, s1_prev} + {{(ACC_WID + 1 - PW){1'b0}}, s1_power};
  assign sum_sat  = sum_full[ACC_WID] ? SatMax : sum_full[ACC_WID-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_first <= 1'b0;
      s0_out   <= 1'b0;
      s0_re    <= '0;
      s0_im    <= '0;
      s0_bin   <= '0;
      s1_valid <= 1'b0;
      s1_out   <= 1'b0;
      s1_power <= '0;
      s1_prev  <= '0;
      s1_bin   <= '0;
      s2_valid <= 1'b0;
      s2_out   <= 1'b0;
      s2_sum   <= '0;
      s2_bin   <= '0;
      sat_q    <= 1'b0;
    end else begin
      s0_valid <= take;
      s0_first <= (frame_q == '0);
      s0_out   <= (frame_q == LastFrame);
      s0_re    <= s_axis_tdata[WIDTH-1:0];
      s0_im    <= s_axis_tdata[2*WIDTH-1:WIDTH];
      s0_bin   <= bin_q;

      s1_valid <= s0_valid;
      s1_out   <= s0_out;
      s1_power <= power;
      // Frame 0 starts a fresh integration, so stale RAM contents are ignored.
      s1_prev  <= s0_first ? '0 : ram_rd;
      s1_bin   <= s0_bin;

      s2_valid <= s1_valid;
      s2_out   <= s1_out;
      s2_sum   <= sum_sat;
      s2_bin   <= s1_bin;
      sat_q    <= s1_valid & sum_full[ACC_WID];
    end
  end

  // Same bin recurs only every FFT_LEN beats, well past the write-back point.
  always_ff @(posedge clk) begin
    if (s2_valid && !s2_out) begin
      ram[s2_bin] <= s2_sum;
    end
    ram_rd <= ram[bin_q];
  end

  // ---------------------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------------------
  logic [EW-1:0]  fifo_mem [OFIFO_DEP];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           push, pop, full, accept;
  logic           ovf_q;
  logic [EW-1:0]  head;

  assign push   = s2_valid & s2_out;
  assign pop    = m_axis_tvalid & m_axis_tready;
  assign full   = (count_q == CW'(OFIFO_DEP));
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is still accepted.
  assign accept = push & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= push & ~accept;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr_q] <= {(s2_bin == LastBin), s2_bin, s2_sum};
    end
  end

  assign head          = fifo_mem[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  // Gate the storage so every output reads 0 while the FIFO is empty (including reset).
  assign m_axis_tdata  = m_axis_tvalid ? head[ACC_WID-1:0] : '0;
  assign m_axis_tuser  = m_axis_tvalid ? 8'(head[ACC_WID +: BW]) : 8'd0;
  assign m_axis_tlast  = m_axis_tvalid & head[EW-1];

  assign event_sync_err = sync_err_q;
  assign event_fifo_ovf = ovf_q;
  assign event_acc_sat  = sat_q;
  assign acc_frame      = frame_q;

endmodule

// File: tb/tb_ospfb_power_acc.sv
module tb_ospfb_power_acc;

  localparam int WIDTH     = 16;
  localparam int FFT_LEN   = 32;
  localparam int ACC_LEN   = 4;
  localparam int ACC_WID   = 33;
  localparam int OFIFO_DEP = 16;
  localparam int BW        = $clog2(FFT_LEN);
  localparam longint MAXV  = (64'sd1 <<< ACC_WID) - 1;

  logic                     clk, rst;
  logic [2*WIDTH-1:0]       s_axis_tdata;
  logic                     s_axis_tvalid, s_axis_tlast;
  logic [7:0]               s_axis_tuser;
  logic [ACC_WID-1:0]       m_axis_tdata;
  logic                     m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]               m_axis_tuser;
  logic                     event_sync_err, event_fifo_ovf, event_acc_sat;
  logic [$clog2(ACC_LEN):0] acc_frame;

  ospfb_power_acc #(
    .WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .ACC_LEN(ACC_LEN), .ACC_WID(ACC_WID),
    .OFIFO_DEP(OFIFO_DEP)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .event_sync_err(event_sync_err), .event_fifo_ovf(event_fifo_ovf),
    .event_acc_sat(event_acc_sat), .acc_frame(acc_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint data; int bin; bit last; } word_t;
  typedef struct { longint due; longint data; int bin; bit last; } pend_t;

  int tests = 0;
  int fails = 0;

  // Reference model state
  longint cyc = 0;
  word_t  mfifo[$];
  pend_t  pend[$];
  longint satq[$];
  longint acc[FFT_LEN];
  bit     m_accum = 0;
  int     m_frame = 0;
  int     m_bin = 0;
  bit     exp_err = 0, exp_ovf = 0, exp_sat = 0;

  // Observed DUT behaviour
  word_t  dut_got[$];
  int     err_cnt = 0, ovf_cnt = 0, sat_cnt = 0;
  bit     seen_valid = 0;
  longint first_valid_cyc = 0;
  longint b0_cyc = 0;
  bit     rand_ready = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: applies the framing, integration and FIFO rules once per clock edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mfifo.delete(); pend.delete(); satq.delete();
      m_accum = 0; m_frame = 0; m_bin = 0;
      exp_err = 0; exp_ovf = 0; exp_sat = 0;
    end else begin
      exp_err = 0; exp_ovf = 0; exp_sat = 0;
      if (mfifo.size() > 0 && m_axis_tready) void'(mfifo.pop_front());
      while (pend.size() > 0 && pend[0].due == cyc) begin
        word_t w;
        w.data = pend[0].data; w.bin = pend[0].bin; w.last = pend[0].last;
        if (mfifo.size() < OFIFO_DEP) mfifo.push_back(w);
        else exp_ovf = 1;
        void'(pend.pop_front());
      end
      if (satq.size() > 0 && satq[0] == cyc) begin
        exp_sat = 1;
        void'(satq.pop_front());
      end
      if (s_axis_tvalid) begin
        int ubin;
        ubin = int'(s_axis_tuser) % FFT_LEN;
        if (!m_accum) begin
          if (s_axis_tlast) begin m_accum = 1; m_frame = 0; m_bin = 0; end
        end else if (ubin != m_bin || s_axis_tlast != (m_bin == FFT_LEN - 1)) begin
          exp_err = 1; m_frame = 0; m_bin = 0; m_accum = s_axis_tlast;
        end else begin
          longint re, im, a;
          pend_t p;
          re = longint'($signed(s_axis_tdata[WIDTH-1:0]));
          im = longint'($signed(s_axis_tdata[2*WIDTH-1:WIDTH]));
          a = re * re + im * im;
          if (m_frame != 0) a = a + acc[m_bin];
          if (a > MAXV) begin a = MAXV; satq.push_back(cyc + 2); end
          acc[m_bin] = a;
          if (m_frame == ACC_LEN - 1) begin
            p.due = cyc + 3; p.data = a; p.bin = m_bin; p.last = (m_bin == FFT_LEN - 1);
            pend.push_back(p);
          end
          if (s_axis_tlast) m_frame = (m_frame + 1) % ACC_LEN;
          m_bin = (m_bin + 1) % FFT_LEN;
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_events", {event_sync_err, event_fifo_ovf, event_acc_sat}, 0);
      chk("rst_acc_frame", acc_frame, 0);
    end else begin
      bit ev;
      ev = (mfifo.size() > 0);
      chk("tvalid", m_axis_tvalid, ev);
      if (ev) begin
        chk("tdata", m_axis_tdata, mfifo[0].data);
        chk("tuser", m_axis_tuser, mfifo[0].bin);
        chk("tlast", m_axis_tlast, mfifo[0].last);
      end
      chk("event_sync_err", event_sync_err, exp_err);
      chk("event_fifo_ovf", event_fifo_ovf, exp_ovf);
      chk("event_acc_sat", event_acc_sat, exp_sat);
      chk("acc_frame", acc_frame, m_frame);
      if (m_axis_tvalid && !seen_valid) begin seen_valid = 1; first_valid_cyc = cyc; end
      if (m_axis_tvalid && m_axis_tready) begin
        word_t w;
        w.data = m_axis_tdata; w.bin = m_axis_tuser; w.last = m_axis_tlast;
        dut_got.push_back(w);
      end
      if (event_sync_err) err_cnt++;
      if (event_fifo_ovf) ovf_cnt++;
      if (event_acc_sat) sat_cnt++;
    end
  end

  task automatic beat(input bit v, input int re, input int im, input int bin, input bit last);
    @(posedge clk); #1;
    s_axis_tvalid = v;
    s_axis_tdata  = {16'(im), 16'(re)};
    s_axis_tuser  = 8'(bin);
    s_axis_tlast  = last;
    if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(0, 0, 0, 0, 0);
  endtask

  // mode 0: 3+4j, 1: re=bin, 2: random with gaps, 3: -32768 both, 4: re=bin+1
  task automatic send_frame(input int mode, input int skip_at, input bit inject);
    int re, im, tu;
    bit tl;
    for (int b = 0; b < FFT_LEN; b++) begin
      if (b == skip_at) continue;
      case (mode)
        0: begin re = 3; im = 4; end
        1: begin re = b; im = 0; end
        3: begin re = -32768; im = -32768; end
        4: begin re = b + 1; im = 0; end
        default: begin
          re = int'($urandom_range(0, 65535)) - 32768;
          im = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
      tu = b;
      tl = (b == FFT_LEN - 1);
      if (inject && $urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 1) == 1) tu = b ^ 3;
        else tl = !tl;
      end
      if (mode == 2 && $urandom_range(0, 7) == 0) idle(1);
      beat(1, re, im, tu, tl);
      if (b == 0) b0_cyc = cyc;
    end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400; i++) begin
      if (mfifo.size() == 0 && pend.size() == 0 && satq.size() == 0) break;
      idle(1);
    end
    chk("drain_pending", mfifo.size() + pend.size(), 0);
    chk("drain_dut_idle", m_axis_tvalid, 0);
    idle(2);
  endtask

  task automatic check_const_spectrum(input string name, input int n, input longint val);
    chk({name, "_count"}, dut_got.size(), n);
    for (int k = 0; k < dut_got.size(); k++) begin
      chk({name, "_data"}, dut_got[k].data, val);
      chk({name, "_bin"}, dut_got[k].bin, k % FFT_LEN);
      chk({name, "_last"}, dut_got[k].last, (k % FFT_LEN) == FFT_LEN - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s0, o0;
    rst = 0; s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0; s_axis_tuser = 0;
    m_axis_tready = 1;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_acc_frame", acc_frame, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    idle(2);

    // 1: prime, then 4 frames of 3+4j -> 32 words of 4*25
    send_frame(0, -1, 0);
    chk("t1_prime_frame", acc_frame, 0);
    dut_got.delete(); seen_valid = 0;
    for (int f = 0; f < ACC_LEN; f++) send_frame(0, -1, 0);
    drain();
    check_const_spectrum("t1", 32, 100);
    chk("t1_latency", first_valid_cyc - b0_cyc, 4);

    // 2: re=bin -> word k = 4*k^2, two spectra
    dut_got.delete();
    for (int f = 0; f < 2 * ACC_LEN; f++) begin
      send_frame(1, -1, 0);
      idle(1);
      chk("t2_acc_frame", acc_frame, (f + 1) % ACC_LEN);
    end
    drain();
    chk("t2_count", dut_got.size(), 64);
    for (int k = 0; k < dut_got.size(); k++)
      chk("t2_data", dut_got[k].data, 4 * (k % 32) * (k % 32));

    // 3: frame 2 skips bin 6 -> one error, that integration lost, next one clean
    dut_got.delete(); e0 = err_cnt;
    send_frame(0, -1, 0);
    send_frame(0, -1, 0);
    send_frame(0, 6, 0);
    idle(2);
    chk("t3_err_pulses", err_cnt - e0, 1);
    chk("t3_realigned_frame", acc_frame, 0);
    for (int f = 0; f < ACC_LEN; f++) send_frame(0, -1, 0);
    drain();
    check_const_spectrum("t3", 32, 100);

    // 4: stall a full spectrum into a 16-deep FIFO
    dut_got.delete(); o0 = ovf_cnt;
    @(posedge clk); #1 m_axis_tready = 0;
    for (int f = 0; f < ACC_LEN; f++) send_frame(4, -1, 0);
    idle(6);
    chk("t4_ovf_pulses", ovf_cnt - o0, 16);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("t4_hold_valid", m_axis_tvalid, 1);
      chk("t4_hold_data", m_axis_tdata, 4);
      chk("t4_hold_user", m_axis_tuser, 0);
    end
    @(posedge clk); #1 m_axis_tready = 1;
    drain();
    chk("t4_count", dut_got.size(), 16);
    for (int k = 0; k < dut_got.size(); k++) begin
      chk("t4_bin", dut_got[k].bin, k);
      chk("t4_data", dut_got[k].data, 4 * (k + 1) * (k + 1));
      chk("t4_last", dut_got[k].last, 0);
    end

    // 5: full-scale negative input saturates a 33-bit accumulator on frame 3 only
    dut_got.delete(); s0 = sat_cnt;
    for (int f = 0; f < ACC_LEN - 1; f++) send_frame(3, -1, 0);
    idle(4);
    chk("t5_no_early_sat", sat_cnt - s0, 0);
    send_frame(3, -1, 0);
    drain();
    chk("t5_sat_pulses", sat_cnt - s0, 32);
    check_const_spectrum("t5", 32, MAXV);

    // Randomized: data, gaps, framing errors and tready
    rand_ready = 1;
    for (int f = 0; f < 48; f++) send_frame(2, -1, 1);
    rand_ready = 0;
    @(posedge clk); #1 m_axis_tready = 1;
    send_frame(2, -1, 0);
    drain();

    // 6: reset during frame 2 with a full FIFO
    @(posedge clk); #1 m_axis_tready = 0;
    send_frame(0, -1, 0);
    for (int f = 0; f < ACC_LEN; f++) send_frame(0, -1, 0);
    idle(6);
    chk("t6_fifo_loaded", m_axis_tvalid, 1);
    send_frame(0, -1, 0);
    send_frame(0, -1, 0);
    for (int b = 0; b < 10; b++) beat(1, 3, 4, b, 0);
    @(posedge clk); #1 s_axis_tvalid = 0;
    #2 rst = 1;
    #1;
    chk("t6_async_tvalid", m_axis_tvalid, 0);
    chk("t6_async_tdata", m_axis_tdata, 0);
    chk("t6_async_acc_frame", acc_frame, 0);
    @(posedge clk); #1 rst = 0; m_axis_tready = 1;
    dut_got.delete();
    for (int b = 10; b < FFT_LEN; b++) beat(1, 3, 4, b, b == FFT_LEN - 1);
    idle(6);
    chk("t6_no_output_after_reset", dut_got.size(), 0);
    chk("t6_realigned_frame", acc_frame, 0);
    for (int f = 0; f < ACC_LEN; f++) send_frame(0, -1, 0);
    drain();
    check_const_spectrum("t6", 32, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
